// File: rtl/axi_xlate_requester.sv
// axi_xlate_requester: AR/AW address translation requester between an upstream AXI master and downstream memory port
// Ports: clk, reset (sync active-high); s_ar*/s_aw* upstream address channels; m_ar*/m_aw* downstream
// translated channels; t_* translator request (virtual addr/len/size, start pulse) and result (phys addr,
// done, drop); r_err/w_err one-cycle error pulses; timeout_flag sticky timeout indicator.
// Optional macro AXI_XLATE_STATS_EN adds saturating r/w ok and drop counters (CNT_W wide).
module axi_xlate_chan #(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT_CYCLES = 64
`ifdef AXI_XLATE_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [7:0]        s_len,
  input  logic [2:0]        s_size,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_len,
  output logic [2:0]        m_size,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] t_v_addr,
  output logic [7:0]        t_len,
  output logic [2:0]        t_size,
  output logic              t_start,
  input  logic [ADDR_W-1:0] t_p_addr,
  input  logic              t_done,
  input  logic              t_drop,
`ifdef AXI_XLATE_STATS_EN
  output logic [CNT_W-1:0]  ok_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
`endif
  output logic              err,
  output logic              to_now
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, ISSUE} state_t;
  state_t state_q;
  logic [TW-1:0] timer_q;
  logic [ADDR_W-1:0] t_v_addr_q, m_addr_q;
  logic [7:0] t_len_q, m_len_q;
  logic [2:0] t_size_q, m_size_q;
  logic s_ready_q, t_start_q, m_valid_q, err_q;
  // drop and done take priority over an expiring timer
  assign to_now = state_q == WAIT && !t_drop && !t_done && timer_q == TMAX;
  assign s_ready = s_ready_q;
  assign t_start = t_start_q;
  assign t_v_addr = t_v_addr_q;
  assign t_len = t_len_q;
  assign t_size = t_size_q;
  assign m_valid = m_valid_q;
  assign m_addr = m_addr_q;
  assign m_len = m_len_q;
  assign m_size = m_size_q;
  assign err = err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      s_ready_q <= 1'b0;
      t_start_q <= 1'b0;
      m_valid_q <= 1'b0;
      err_q <= 1'b0;
      t_v_addr_q <= '0;
      t_len_q <= '0;
      t_size_q <= '0;
      m_addr_q <= '0;
      m_len_q <= '0;
      m_size_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE:
          if (s_valid && s_ready_q) begin
            t_v_addr_q <= s_addr;
            t_len_q <= s_len;
            t_size_q <= s_size;
            s_ready_q <= 1'b0;
            t_start_q <= 1'b1;
            state_q <= REQ;
          end else s_ready_q <= 1'b1;
        REQ: begin
          t_start_q <= 1'b0;
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT:
          if (t_drop || to_now) begin
            err_q <= 1'b1;
            state_q <= IDLE;
          end else if (t_done) begin
            m_addr_q <= t_p_addr;
            m_len_q <= t_len_q;
            m_size_q <= t_size_q;
            m_valid_q <= 1'b1;
            state_q <= ISSUE;
          end else timer_q <= timer_q + 1'b1;
        ISSUE:
          if (m_ready) begin
            m_valid_q <= 1'b0;
            state_q <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef AXI_XLATE_STATS_EN
  logic [CNT_W-1:0] ok_cnt_q, drop_cnt_q;
  logic ok_inc, drop_inc;
  assign ok_inc = state_q == WAIT && !t_drop && t_done;
  assign drop_inc = state_q == WAIT && (t_drop || to_now);
  assign ok_cnt = ok_cnt_q;
  assign drop_cnt = drop_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      ok_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (ok_inc && !(&ok_cnt_q)) ok_cnt_q <= ok_cnt_q + 1'b1;
      if (drop_inc && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end
`endif
endmodule

module axi_xlate_requester #(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT_CYCLES = 64
`ifdef AXI_XLATE_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic [7:0]        s_awlen,
  input  logic [2:0]        s_awsize,
  input  logic              s_awvalid,
  output logic              s_awready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ADDR_W-1:0] t_v_raddr,
  output logic [7:0]        t_r_len,
  output logic [2:0]        t_r_size,
  output logic              t_rstart,
  input  logic [ADDR_W-1:0] t_p_raddr,
  input  logic              t_rdone,
  input  logic              t_rdrop,
  output logic [ADDR_W-1:0] t_v_waddr,
  output logic [7:0]        t_w_len,
  output logic [2:0]        t_w_size,
  output logic              t_wstart,
  input  logic [ADDR_W-1:0] t_p_waddr,
  input  logic              t_wdone,
  input  logic              t_wdrop,
  output logic              r_err,
  output logic              w_err,
`ifdef AXI_XLATE_STATS_EN
  output logic [CNT_W-1:0]  r_ok_cnt,
  output logic [CNT_W-1:0]  r_drop_cnt,
  output logic [CNT_W-1:0]  w_ok_cnt,
  output logic [CNT_W-1:0]  w_drop_cnt,
`endif
  output logic              timeout_flag
);
  logic r_to, w_to, timeout_flag_q;
  assign timeout_flag = timeout_flag_q;
  // raised on the same edge that issues the timeout error pulse
  always_ff @(posedge clk) timeout_flag_q <= reset ? 1'b0 : timeout_flag_q | r_to | w_to;
  axi_xlate_chan #(
    .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`ifdef AXI_XLATE_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) u_rd (
    .clk(clk), .reset(reset),
    .s_addr(s_araddr), .s_len(s_arlen), .s_size(s_arsize), .s_valid(s_arvalid), .s_ready(s_arready),
    .m_addr(m_araddr), .m_len(m_arlen), .m_size(m_arsize), .m_valid(m_arvalid), .m_ready(m_arready),
    .t_v_addr(t_v_raddr), .t_len(t_r_len), .t_size(t_r_size), .t_start(t_rstart),
    .t_p_addr(t_p_raddr), .t_done(t_rdone), .t_drop(t_rdrop),
`ifdef AXI_XLATE_STATS_EN
    .ok_cnt(r_ok_cnt), .drop_cnt(r_drop_cnt),
`endif
    .err(r_err), .to_now(r_to)
  );
  axi_xlate_chan #(
    .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`ifdef AXI_XLATE_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) u_wr (
    .clk(clk), .reset(reset),
    .s_addr(s_awaddr), .s_len(s_awlen), .s_size(s_awsize), .s_valid(s_awvalid), .s_ready(s_awready),
    .m_addr(m_awaddr), .m_len(m_awlen), .m_size(m_awsize), .m_valid(m_awvalid), .m_ready(m_awready),
    .t_v_addr(t_v_waddr), .t_len(t_w_len), .t_size(t_w_size), .t_start(t_wstart),
    .t_p_addr(t_p_waddr), .t_done(t_wdone), .t_drop(t_wdrop),
`ifdef AXI_XLATE_STATS_EN
    .ok_cnt(w_ok_cnt), .drop_cnt(w_drop_cnt),
`endif
    .err(w_err), .to_now(w_to)
  );
endmodule

// File: doc/axi_xlate_requester.md
Name: axi_xlate_requester

Overview:
- Initiator side of the MMU address-translation interface; sits between an upstream AXI master's AR/AW channels and the downstream memory AXI port.
- Accepts each address beat and issues a start pulse plus virtual address, len and size to the translator.
- Waits for the translator's done or drop, then forwards the physical address downstream, or flags an error.
- Read and write paths are independent, identical FSMs.

Parameters:
- ADDR_W, 32, address width (virtual and physical).
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before the request is abandoned; must be >= 4.
- CNT_W, 16, statistics counter width (optional feature only).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- s_araddr / s_awaddr  input  ADDR_W  upstream virtual address.
- s_arlen / s_awlen  input  8  upstream burst length.
- s_arsize / s_awsize  input  3  upstream beat size.
- s_arvalid / s_awvalid  input  1  upstream valid.
- s_arready / s_awready  output  1  upstream ready.
- m_araddr / m_awaddr  output  ADDR_W  downstream physical address.
- m_arlen / m_awlen, m_arsize / m_awsize  output  8 / 3  forwarded len and size.
- m_arvalid / m_awvalid  output  1  downstream valid.
- m_arready / m_awready  input  1  downstream ready.
- t_v_raddr / t_v_waddr  output  ADDR_W  virtual address to the translator.
- t_r_len / t_w_len, t_r_size / t_w_size  output  8 / 3  to the translator.
- t_rstart / t_wstart  output  1  start pulse (the translator counts rising edges).
- t_p_raddr / t_p_waddr  input  ADDR_W  translated address.
- t_rdone / t_wdone, t_rdrop / t_wdrop  input  1  translator result.
- r_err / w_err  output  1  one-cycle pulse on drop or timeout.
- timeout_flag  output  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset:
  - Both FSMs go to IDLE.
  - All outputs are 0, including s_xready, t_xstart, m_xvalid, x_err, timeout_flag and the address/len/size registers.
  - s_xready rises in the first cycle after reset deasserts.
- FSM per channel: IDLE -> REQ -> WAIT -> ISSUE -> IDLE.
- IDLE:
  - s_xready = 1.
  - On s_xvalid & s_xready, latch addr/len/size into t_v_x*, then go to REQ.
- REQ:
  - t_xstart = 1 for exactly this one cycle.
  - Clear the wait timer, then go to WAIT.
- WAIT:
  - t_v_x* held stable.
  - t_xdrop = 1 -> x_err pulses next cycle, then IDLE; nothing is forwarded.
  - t_xdone = 1 (no drop) -> capture t_p_xaddr into m_xaddr and copy len/size, then ISSUE.
  - done & drop in the same cycle -> drop wins.
  - Timer reaches TIMEOUT_CYCLES-1 with neither -> x_err pulse, timeout_flag <= 1, then IDLE.
- ISSUE:
  - m_xvalid = 1; m_x* held stable until m_xready.
  - On handshake, m_xvalid deasserts next cycle and the FSM returns to IDLE.
  - m_xvalid never drops without a handshake.
- done/drop seen in IDLE, REQ or ISSUE (stale after a timeout) are ignored.
- Spacing: t_xstart is low for at least 2 cycles between pulses, so every request is a distinct rising edge.
- Latency: upstream handshake at cycle 0 -> t_xstart at cycle 1 -> done at cycle k -> m_xvalid at cycle k+1.
- Throughput: one outstanding request per channel; s_xready is low from REQ through ISSUE.
- Read/write independence: simultaneous AR and AW are processed in parallel with no shared state except timeout_flag.
- reset asserted mid-transaction: that cycle's edge returns the FSMs to IDLE and zeroes outputs; the in-flight request is discarded.

Optional Feature:
- Macro: AXI_XLATE_STATS_EN.
- Defined:
  - Adds outputs r_ok_cnt, r_drop_cnt, w_ok_cnt, w_drop_cnt, each CNT_W wide, reset to 0.
  - ok_cnt increments on WAIT->ISSUE; drop_cnt increments on drop or timeout.
  - Counters saturate at all-ones.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Read translation: s_araddr=0x0800_0010, len=3, translator stub adds segment 1 * 0x1000 and pulses done 2 cycles after the start edge -> single t_rstart pulse; m_araddr=0x0800_1010, m_arlen=3, m_arvalid held until m_arready.
- Drop: t_wdrop asserted in WAIT for s_awaddr=0x1000_0000 -> w_err one-cycle pulse, m_awvalid never asserts, s_awready=1 two cycles later.
- Timeout: stub never responds, TIMEOUT_CYCLES=8 -> r_err pulse after 8 WAIT cycles and timeout_flag=1; a late t_rdone is ignored.
- Backpressure and concurrency: AR and AW accepted in the same cycle with m_arready held low for 5 cycles -> write path completes independently; m_araddr stays stable throughout; two back-to-back reads produce two distinct t_rstart rising edges.
- Reset mid-WAIT: reset for 1 cycle -> all outputs 0; next request is translated correctly.
- AXI_XLATE_STATS_EN build: 3 ok reads plus 1 dropped write -> r_ok_cnt=3, w_drop_cnt=1.
